// File: rtl/gpio_pkg.sv
// gpio_pkg: register map of the GPIO controller and the register-select type decoded from address[5:2].
package gpio_pkg;
   localparam logic [7:0] GPIO_DIR_OFS        = 8'h00;
   localparam logic [7:0] GPIO_OUT_OFS        = 8'h04;
   localparam logic [7:0] GPIO_IN_OFS         = 8'h08;
   localparam logic [7:0] GPIO_OUT_SET_OFS    = 8'h0C;
   localparam logic [7:0] GPIO_OUT_CLR_OFS    = 8'h10;
   localparam logic [7:0] GPIO_IRQ_EN_OFS     = 8'h14;
   localparam logic [7:0] GPIO_RISE_EN_OFS    = 8'h18;
   localparam logic [7:0] GPIO_FALL_EN_OFS    = 8'h1C;
   localparam logic [7:0] GPIO_IRQ_STATUS_OFS = 8'h20;
   localparam logic [7:0] GPIO_DEBOUNCE_OFS   = 8'h24;

   localparam int GPIO_SEL_W = 4;

   typedef enum logic [GPIO_SEL_W-1:0] {
      SEL_DIR      = 4'h0,
      SEL_OUT      = 4'h1,
      SEL_IN       = 4'h2,
      SEL_OUT_SET  = 4'h3,
      SEL_OUT_CLR  = 4'h4,
      SEL_IRQ_EN   = 4'h5,
      SEL_RISE_EN  = 4'h6,
      SEL_FALL_EN  = 4'h7,
      SEL_STATUS   = 4'h8,
      SEL_DEBOUNCE = 4'h9
   } gpio_sel_e;
endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: per-pin input synchroniser with rise/fall pulses aligned to the edge the level updates.
// With GPIO_DEBOUNCE_EN defined, a counter holds the level until the input differs for i_db_n cycles.
module gpio_pin_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_pad,
   input  logic [DB_CNT_W-1:0] i_db_n,
   output logic                o_level,
   output logic                o_rise,
   output logic                o_fall
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_next;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};

`ifdef GPIO_DEBOUNCE_EN
   logic                r_f;
   logic [DB_CNT_W-1:0] r_cnt;
   logic [DB_CNT_W-1:0] w_cnt_nx;
   logic                w_diff;
   logic                w_done;

   assign w_diff   = r_sync[SYNC_STAGES-1] != r_f;
   assign w_cnt_nx = r_cnt + 1'b1;
   assign w_done   = w_diff && (w_cnt_nx == i_db_n);
   // bypass tracks the stage before the output so r_f equals the synchroniser output
   assign w_next   = (i_db_n == '0) ? r_sync[SYNC_STAGES-2]
                   : w_done         ? r_sync[SYNC_STAGES-1] : r_f;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_f   <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_f   <= w_next;
         r_cnt <= (i_db_n != '0 && w_diff && !w_done) ? w_cnt_nx : '0;
      end

   assign o_level = r_f;
`else
   logic w_unused;

   assign w_unused = ^i_db_n;
   assign w_next   = r_sync[SYNC_STAGES-2];
   assign o_level  = r_sync[SYNC_STAGES-1];
`endif

   assign o_rise = w_next & ~o_level;
   assign o_fall = ~w_next & o_level;
endmodule

// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO bank with atomic set/clear, synchronised input and W1C edge interrupts.
// Define GPIO_DEBOUNCE_EN to add the DEBOUNCE register and per-pin debounce counters.
module gpio_controller
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 20,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      address,
   input  logic [31:0]      write_data,
   output logic [31:0]      read_data,
   inout  wire  [WIDTH-1:0] gpios,
   output logic             irq
);
   logic [WIDTH-1:0]    r_dir, r_out, r_irq_en, r_rise_en, r_fall_en, r_status;
   logic [31:0]         r_read_data;
   logic                r_irq;
   logic [WIDTH-1:0]    w_in, w_rise, w_fall, w_wd, w_clr;
   logic [GPIO_SEL_W-1:0] w_sel;
   logic [31:0]         w_rd;
   logic [DB_CNT_W-1:0] w_db_n;
   logic                w_unused;

   assign w_sel    = address[5:2];
   assign w_wd     = write_data[WIDTH-1:0];
   assign w_clr    = (write && w_sel == SEL_STATUS) ? w_wd : '0;
   assign w_unused = ^{address[31:6], address[1:0], write_data};

`ifdef GPIO_DEBOUNCE_EN
   logic [DB_CNT_W-1:0] r_debounce;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                                r_debounce <= '0;
      else if (write && w_sel == SEL_DEBOUNCE)   r_debounce <= write_data[DB_CNT_W-1:0];

   assign w_db_n = r_debounce;
`else
   assign w_db_n = '0;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign gpios[i] = r_dir[i] ? r_out[i] : 1'bz;
      gpio_pin_filter #(
         .SYNC_STAGES(SYNC_STAGES),
         .DB_CNT_W   (DB_CNT_W)
      ) u_filter (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_pad  (gpios[i]),
         .i_db_n (w_db_n),
         .o_level(w_in[i]),
         .o_rise (w_rise[i]),
         .o_fall (w_fall[i])
      );
   end

   always_comb begin
      w_rd = '0;
      case (w_sel)
         SEL_DIR:      w_rd[WIDTH-1:0] = r_dir;
         SEL_OUT:      w_rd[WIDTH-1:0] = r_out;
         SEL_IN:       w_rd[WIDTH-1:0] = w_in;
         SEL_IRQ_EN:   w_rd[WIDTH-1:0] = r_irq_en;
         SEL_RISE_EN:  w_rd[WIDTH-1:0] = r_rise_en;
         SEL_FALL_EN:  w_rd[WIDTH-1:0] = r_fall_en;
         SEL_STATUS:   w_rd[WIDTH-1:0] = r_status;
`ifdef GPIO_DEBOUNCE_EN
         SEL_DEBOUNCE: w_rd[DB_CNT_W-1:0] = r_debounce;
`endif
         default:      ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_dir       <= '0;
         r_out       <= '0;
         r_irq_en    <= '0;
         r_rise_en   <= '0;
         r_fall_en   <= '0;
         r_status    <= '0;
         r_read_data <= '0;
         r_irq       <= 1'b0;
      end else begin
         if (write && w_sel == SEL_DIR)     r_dir     <= w_wd;
         if (write && w_sel == SEL_IRQ_EN)  r_irq_en  <= w_wd;
         if (write && w_sel == SEL_RISE_EN) r_rise_en <= w_wd;
         if (write && w_sel == SEL_FALL_EN) r_fall_en <= w_wd;
         r_out <= !write                ? r_out
                : (w_sel == SEL_OUT)     ? w_wd
                : (w_sel == SEL_OUT_SET) ? r_out | w_wd
                : (w_sel == SEL_OUT_CLR) ? r_out & ~w_wd : r_out;
         // a new edge event wins over a W1C of the same bit
         r_status    <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
         r_irq       <= |(r_status & r_irq_en);
         r_read_data <= read ? w_rd : '0;
      end

   assign read_data = r_read_data;
   assign irq       = r_irq;
endmodule
